// File: rtl/vram_pkg.sv
// Shared definitions for the video/tile RAM read and write paths.
package vram_pkg;

    localparam int unsigned ADDRESS_WIDTH    = 12;
    localparam int unsigned DEPTH            = 1200;
    localparam int unsigned BYTE_WIDTH       = 8;
    localparam int unsigned NUM_BYTES        = 4;
    localparam int unsigned BYTE_IDX_WIDTH   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned BYTE_COUNT_WIDTH = $clog2(DEPTH * NUM_BYTES + 1);

    typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } rd_state_t;

    // Word address increment with wrap at the top of the RAM.
    function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr == ADDRESS_WIDTH'(DEPTH - 1)) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/vram_byte_stream_reader_if.sv
// RAM read port plus byte stream of the reader; master is the reader side.
interface vram_byte_stream_reader_if;
    import vram_pkg::*;

    logic [ADDRESS_WIDTH-1:0] raddr;
    word_t                    q;
    logic [BYTE_WIDTH-1:0]    out_byte;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output raddr,
        output out_byte,
        output out_valid,
        output out_last,
        input  q,
        input  out_ready
    );

    modport slave (
        input  raddr,
        input  out_byte,
        input  out_valid,
        input  out_last,
        output q,
        output out_ready
    );

endinterface

// File: rtl/vram_word_fifo2.sv
// Two-entry word FIFO; exposes its next-state head/count so a registered consumer can track it.
module vram_word_fifo2
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  word_t      wdata,
    output logic [1:0] count,
    output logic [1:0] count_next,
    output word_t      head_next
);

    word_t entry0, entry1;
    word_t entry0_n, entry1_n;

    always_comb begin
        entry0_n   = entry0;
        entry1_n   = entry1;
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0_n = wdata;
                    else               entry1_n = wdata;
                    count_next = count + 2'd1;
                end
                2'b01: begin
                    entry0_n   = entry1;
                    count_next = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0_n = wdata;
                    end else begin
                        entry0_n = entry1;
                        entry1_n = wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_next = entry0_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            entry0 <= entry0_n;
            entry1 <= entry1_n;
            count  <= count_next;
        end
    end

endmodule

// File: rtl/vram_byte_stream_reader.sv
// Fetches a run of RAM words and streams them out byte 0 first on a valid/ready port.
module vram_byte_stream_reader
    import vram_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   word_count,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    vram_byte_stream_reader_if.master bus
);

    localparam logic [BYTE_IDX_WIDTH-1:0] LAST_BYTE_IDX = BYTE_IDX_WIDTH'(NUM_BYTES - 1);

    rd_state_t                   state;
    logic [ADDRESS_WIDTH-1:0]    rd_ptr;
    logic [ADDRESS_WIDTH:0]      words_left_issue;
    logic [BYTE_COUNT_WIDTH-1:0] bytes_left, bytes_left_n;
    logic [BYTE_IDX_WIDTH-1:0]   byte_idx, byte_idx_n;
    // pending: address on raddr, RAM sampling it; rvalid: its data is on q now.
    logic                        pending, rvalid;

    logic       in_run, handshake, issue;
    logic       fifo_pop, fifo_flush;
    logic [1:0] fifo_count, fifo_count_next;
    word_t      fifo_head_next;

    always_comb begin
        in_run       = (state == RUN);
        handshake    = bus.out_valid && bus.out_ready;
        fifo_flush   = in_run && abort;
        fifo_pop     = in_run && handshake && (byte_idx == LAST_BYTE_IDX);
        issue        = in_run && !abort && (words_left_issue != '0) &&
                       (({1'b0, fifo_count} + {2'b0, pending} + {2'b0, rvalid}) < 3'd2);
        byte_idx_n   = byte_idx;
        bytes_left_n = bytes_left;
        if (handshake) begin
            byte_idx_n   = (byte_idx == LAST_BYTE_IDX) ? '0 : byte_idx + 1'b1;
            bytes_left_n = bytes_left - 1'b1;
        end
    end

    vram_word_fifo2 u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rvalid),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .wdata      (bus.q),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .head_next  (fifo_head_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            words_left_issue <= '0;
            bytes_left       <= '0;
            byte_idx         <= '0;
            pending          <= 1'b0;
            rvalid           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.raddr        <= '0;
            bus.out_byte     <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_last     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            // First read issues on the start edge itself.
                            state            <= RUN;
                            busy             <= 1'b1;
                            bus.raddr        <= base_addr;
                            rd_ptr           <= next_addr(base_addr);
                            words_left_issue <= word_count - 1'b1;
                            bytes_left       <= BYTE_COUNT_WIDTH'(word_count) *
                                                BYTE_COUNT_WIDTH'(NUM_BYTES);
                            byte_idx         <= '0;
                            pending          <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    pending    <= issue;
                    rvalid     <= pending;
                    byte_idx   <= byte_idx_n;
                    bytes_left <= bytes_left_n;
                    if (issue) begin
                        bus.raddr        <= rd_ptr;
                        rd_ptr           <= next_addr(rd_ptr);
                        words_left_issue <= words_left_issue - 1'b1;
                    end
                    // Output mirrors the FIFO's next head so it is registered yet bubble-free.
                    bus.out_valid <= (fifo_count_next != 2'd0);
                    bus.out_byte  <= fifo_head_next[byte_idx_n];
                    bus.out_last  <= (fifo_count_next != 2'd0) &&
                                     (bytes_left_n == BYTE_COUNT_WIDTH'(1));
                    if (abort || (handshake && bus.out_last)) begin
                        state         <= FINISH;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        pending       <= 1'b0;
                        rvalid        <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_byte_stream_reader.sv
// Randomized bench for vram_byte_stream_reader against a byte-queue reference model.
module tb_vram_byte_stream_reader;
    import vram_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     start = 1'b0;
    logic [ADDRESS_WIDTH-1:0] base_addr = '0;
    logic [ADDRESS_WIDTH:0]   word_count = '0;
    logic                     abort = 1'b0;
    logic                     busy, done;

    logic [31:0] ram [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    vram_byte_stream_reader_if bus_if ();

    vram_byte_stream_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // RAM with registered read: q follows raddr by one clock.
    always @(posedge clk) bus_if.q <= ram[bus_if.raddr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transfer; mode 0 ready=1, mode 1 ready pattern 1,0,0,1, mode 2 random ready.
    task automatic run_xfer(input int base, input int count, input int mode,
                            input int abort_at, input bit poke_start);
        logic [BYTE_WIDTH-1:0]    exp_q[$];
        logic [31:0]              word;
        logic [BYTE_WIDTH-1:0]    stall_byte;
        logic [ADDRESS_WIDTH-1:0] raddr_before;
        int  total, got, first_valid, last_hs, done_cyc, abort_cyc, budget;
        bit  stalled, finished, aborted;

        exp_q = {};
        for (int w = 0; w < count; w++) begin
            word = ram[(base + w) % DEPTH];
            for (int b = 0; b < NUM_BYTES; b++) exp_q.push_back(word[b*BYTE_WIDTH +: BYTE_WIDTH]);
        end
        total        = exp_q.size();
        got          = 0;
        first_valid  = -1;
        last_hs      = -1;
        done_cyc     = -1;
        abort_cyc    = -1;
        stalled      = 1'b0;
        finished     = 1'b0;
        aborted      = 1'b0;
        stall_byte   = '0;
        budget       = 40 + total * 10;
        raddr_before = bus_if.raddr;

        assert (count >= 0 && count <= int'(DEPTH)) else $error("word_count %0d illegal", count);
        start      = 1'b1;
        base_addr  = ADDRESS_WIDTH'(base);
        word_count = (ADDRESS_WIDTH + 1)'(count);
        @(posedge clk); #1;
        start = 1'b0;

        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            case (mode)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            abort = 1'b0;
            if (abort_at >= 0 && !aborted && got == abort_at) begin
                abort            = 1'b1;
                bus_if.out_ready = 1'b0;
                aborted          = 1'b1;
                abort_cyc        = cyc;
            end
            if (poke_start && cyc == 3) begin
                start      = 1'b1;
                base_addr  = ADDRESS_WIDTH'((base + 7) % DEPTH);
                word_count = 1;
            end else begin
                start = 1'b0;
            end

            @(negedge clk);
            if (cyc == 0 && count > 0) begin
                check_eq("raddr_first", bus_if.raddr, base);
                check_eq("busy_run", busy, 1);
            end
            if (cyc == 0 && count == 0) check_eq("raddr_hold", bus_if.raddr, raddr_before);
            if (cyc == 1 && count > 1) check_eq("raddr_second", bus_if.raddr, (base + 1) % DEPTH);
            if (stalled) begin
                check_eq("stall_valid", bus_if.out_valid, 1);
                check_eq("stall_byte", bus_if.out_byte, stall_byte);
            end
            stalled    = bus_if.out_valid && !bus_if.out_ready && !abort;
            stall_byte = bus_if.out_byte;
            if (first_valid < 0 && bus_if.out_valid) first_valid = cyc;
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (got < total) begin
                    check_eq("byte", bus_if.out_byte, exp_q[got]);
                    check_eq("last", bus_if.out_last, (got == total - 1));
                end else begin
                    check_eq("extra_byte", got, total);
                end
                got++;
                last_hs = cyc;
            end
            if (done) begin
                finished = 1'b1;
                done_cyc = cyc;
                check_eq("busy_at_done", busy, 0);
                if (aborted) begin
                    check_eq("abort_valid", bus_if.out_valid, 0);
                    check_eq("abort_done_cyc", cyc, abort_cyc + 1);
                end else begin
                    check_eq("byte_count", got, total);
                    if (count == 0) check_eq("zero_done_cyc", cyc, 0);
                    else            check_eq("done_after_last", cyc, last_hs + 1);
                end
            end
            @(posedge clk); #1;
        end

        start = 1'b0;
        abort = 1'b0;
        if (!finished) check_eq("done_timeout", 0, 1);
        if (count == 0) check_eq("zero_no_valid", first_valid, -1);
        if (count > 0 && !aborted && finished) check_eq("first_valid_cyc", first_valid, 2);
        if (mode == 0 && count > 0 && !aborted && finished)
            check_eq("no_bubble_done", done_cyc, total + 2);
    endtask

    task automatic reset_mid_stream();
        start            = 1'b1;
        base_addr        = 100;
        word_count       = 8;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("pre_reset_valid", bus_if.out_valid, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_raddr", bus_if.raddr, 0);
        check_eq("rst_out_byte", bus_if.out_byte, 0);
        check_eq("rst_out_valid", bus_if.out_valid, 0);
        check_eq("rst_out_last", bus_if.out_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int base, count, mode, abort_at;

        for (int i = 0; i < int'(DEPTH); i++) ram[i] = $urandom;
        ram[0]       = 32'h4433_2211;
        ram[1]       = 32'h8877_6655;
        ram[10]      = 32'hDEAD_BEEF;
        bus_if.out_ready = 1'b0;

        #12;
        check_eq("init_raddr", bus_if.raddr, 0);
        check_eq("init_valid", bus_if.out_valid, 0);
        check_eq("init_busy", busy, 0);
        check_eq("init_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(0, 2, 0, -1, 1'b0);
        run_xfer(int'(DEPTH) - 1, 2, 0, -1, 1'b0);
        run_xfer(50, 3, 1, -1, 1'b0);
        run_xfer(300, 0, 0, -1, 1'b0);
        run_xfer(20, 4, 0, 5, 1'b0);
        run_xfer(10, 1, 0, -1, 1'b0);

        reset_mid_stream();
        run_xfer(200, 3, 1, -1, 1'b1);
        run_xfer(0, 2, 0, -1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            base  = (t % 4 == 0) ? int'($urandom_range(DEPTH - 3, DEPTH - 1))
                                 : int'($urandom_range(0, DEPTH - 1));
            count = int'($urandom_range(0, 6));
            mode  = int'($urandom_range(0, 2));
            abort_at = ($urandom_range(0, 3) == 0 && count > 0)
                       ? int'($urandom_range(0, count * NUM_BYTES - 1)) : -1;
            run_xfer(base, count, mode, abort_at, t % 5 == 1 && count > 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_errors);
        $finish;
    end

endmodule
